// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // Default operand, quotient and remainder width.
  localparam int DIV_WIDTH = 32;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // A divide by zero returns a quotient of all ones.
  // This is the fill bit, replicated to the operand width.
  localparam logic DIV0_Q_BIT = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// Shifts {partial remainder, dividend} left by one and trial-subtracts the divisor.
// If the trial result is non-negative it is kept and the quotient bit is 1.
// Otherwise the shifted value is restored and the quotient bit is 0.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] shreg_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] shreg_o
);

  // One extra guard bit above the partial remainder.
  // The borrow of the trial subtract then lands in a bit of its own.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_neg;

  // Trial subtract, then keep the result or restore the shifted value.
  always_comb begin
    shifted   = {rem_i, shreg_i[WIDTH-1]};
    trial     = shifted - {2'b00, divisor_i};
    trial_neg = trial[WIDTH+1];
    if (trial_neg) begin
      rem_o   = shifted[WIDTH:0];
      shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o   = trial[WIDTH:0];
      shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per clock.
//
// Handshake: start is sampled only while the controller is in IDLE.
// busy is high from the cycle after acceptance through the done cycle.
// done is a single-cycle pulse.
// quotient, remainder and div_by_zero are valid from the done cycle.
// They hold until the next accepted start.
// start while busy is ignored, and the operands are sampled only on acceptance.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] dvs_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] shreg_d;

  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  // Operand sign detection and magnitude extraction at the input.
  // Unsigned operands are taken as raw magnitudes.
  always_comb begin
    dividend_neg = is_signed & dividend[WIDTH-1];
    divisor_neg  = is_signed & divisor[WIDTH-1];
    dividend_mag = dividend_neg ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor_neg  ? (~divisor  + 1'b1) : divisor;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .shreg_i  (shreg_q),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .shreg_o  (shreg_d)
  );

  // Controller FSM and all datapath/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      shreg_q     <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              // A zero divisor skips the iterations entirely.
              quotient_q  <= {WIDTH{DIV0_Q_BIT}};
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= DONE;
            end else begin
              shreg_q <= dividend_mag;
              dvs_q   <= divisor_mag;
              rem_q   <= '0;
              q_neg_q <= dividend_neg ^ divisor_neg;
              r_neg_q <= dividend_neg;
              cnt_q   <= CW'(WIDTH);
              dbz_q   <= 1'b0;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q   <= rem_d;
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // Quotient truncates toward zero; the remainder takes the dividend's sign.
          quotient_q  <= q_neg_q ? (~shreg_q + 1'b1) : shreg_q;
          remainder_q <= r_neg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
          done_q      <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider.
// It uses a vector table plus hand-written multi-cycle sequences.
module tb_seq_divider;

  localparam int W = 32;
  localparam int LAT_RUN = W + 2;
  localparam int LAT_DBZ = 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  vec_t vecs[13];

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state_o(dbg_state)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive start during an IDLE cycle.
  // Return #1 after the accepting edge, which is the first busy cycle.
  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for done, starting at cycle offset lat0 after the start-sampling cycle.
  // Check latency, busy and the results.
  task automatic wait_result(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edbz, input int elat, input int lat0);
    int lat;
    int busy_low;
    lat = lat0;
    busy_low = 0;
    while (!done && lat < elat + 20) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_lat"}, W'(lat), W'(elat));
    check({name, "_busy_low"}, W'(busy_low), '0);
    check({name, "_busy_at_done"}, W'(busy), W'(1));
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dbz"}, W'(div_by_zero), W'(edbz));
  endtask

  // Step into the IDLE cycle that follows done and check the handshake dropped.
  task automatic to_idle(input string name);
    @(posedge clk);
    #1;
    check({name, "_done_clr"}, W'(done), '0);
    check({name, "_busy_clr"}, W'(busy), '0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    //       sgn   a             b             q             r             dbz
    vecs[0]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};
    vecs[3]  = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
    vecs[6]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        1'b0};
    vecs[8]  = '{1'b1, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0};
    vecs[9]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
    vecs[10] = '{1'b0, 32'd6,        32'd3,        32'd2,        32'd0,        1'b0};
    vecs[11] = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
    vecs[12] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_dbz", W'(div_by_zero), '0);
    check("rst_state", W'(dbg_state), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz,
                  (vecs[i].b == '0) ? LAT_DBZ : LAT_RUN, 1);
      to_idle($sformatf("vec%0d", i));
    end

    // A start pulse mid-operation is ignored.
    // A start held through DONE into IDLE is accepted.
    launch(1'b0, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd4;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'd55;
    divisor  = 32'd5;
    wait_result("ignore_start", 32'd14, 32'd2, 1'b0, LAT_RUN, 10);
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd4;
    @(posedge clk);
    #1;
    check("held_idle_busy", W'(busy), '0);
    check("held_idle_state", W'(dbg_state), '0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_result("held_start", 32'd2, 32'd1, 1'b0, LAT_RUN, 1);
    to_idle("held_start");

    // Asynchronous reset mid-divide: outputs clear at once and no done pulse follows.
    launch(1'b0, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), '0);
    check("arst_done", W'(done), '0);
    check("arst_q", quotient, '0);
    check("arst_r", remainder, '0);
    check("arst_state", W'(dbg_state), '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) stray++;
      end
      check("arst_no_done", W'(stray), '0);
    end
    launch(1'b0, 32'd9, 32'd4);
    wait_result("after_rst", 32'd2, 32'd1, 1'b0, LAT_RUN, 1);
    to_idle("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
